// File: rtl/cgra_config_sequencer.sv
// ---------------------------------------------------------------------------
// cgra_config_sequencer
//
// Purpose:
//   Drives one configure-and-run session of a CGRA array:
//     1. hold the array in reset,
//     2. stream a bitstream into it one beat at a time,
//     3. let it run for a fixed number of cycles,
//     4. report completion.
//   The session is started by start_in. abort_in or reset_in cancels it.
//
// Ports:
//   clk_in           - single clock; all state changes on its rising edge
//   reset_in         - asynchronous, active-low reset
//   start_in         - start request, honoured only in IDLE or DONE
//   abort_in         - return to IDLE from any state; wins over start_in
//   cfg_valid_in     - source presents a configuration beat
//   cfg_ready_out    - sequencer accepts a beat this cycle (registered)
//   cfg_addr_in      - beat address (CFG_ADDR_W bits)
//   cfg_data_in      - beat data (CFG_DATA_W bits)
//   cfg_last_in      - marks the final beat of the bitstream
//   array_reset_out  - active-high reset to the array
//   config_addr_out  - address to the array; 0 when no fresh beat
//   config_data_out  - data to the array; 0 when no fresh beat
//   config_done_out  - bitstream fully delivered
//   run_done_out     - run window elapsed
//   beat_count_out   - accepted beats this session, saturating at 0xFFFF
// ---------------------------------------------------------------------------
module cgra_config_sequencer #(
  parameter int CFG_ADDR_W = 32,
  parameter int CFG_DATA_W = 32,
  parameter int RST_CYCLES = 3,
  parameter int RUN_CYCLES = 10000
) (
  input  logic                  clk_in,
  input  logic                  reset_in,
  input  logic                  start_in,
  input  logic                  abort_in,
  input  logic                  cfg_valid_in,
  output logic                  cfg_ready_out,
  input  logic [CFG_ADDR_W-1:0] cfg_addr_in,
  input  logic [CFG_DATA_W-1:0] cfg_data_in,
  input  logic                  cfg_last_in,
  output logic                  array_reset_out,
  output logic [CFG_ADDR_W-1:0] config_addr_out,
  output logic [CFG_DATA_W-1:0] config_data_out,
  output logic                  config_done_out,
  output logic                  run_done_out,
  output logic [15:0]           beat_count_out
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_ARST = 3'd1;
  localparam logic [2:0] S_LOAD = 3'd2;
  localparam logic [2:0] S_RUN  = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  // The counters only have to reach N-1.
  // A single-cycle window still needs a 1-bit counter.
  localparam int RST_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam int RUN_W = (RUN_CYCLES > 1) ? $clog2(RUN_CYCLES) : 1;
  localparam logic [RST_W-1:0] RST_LAST = RST_W'(RST_CYCLES - 1);
  localparam logic [RUN_W-1:0] RUN_LAST = RUN_W'(RUN_CYCLES - 1);

  logic [2:0]            state_q, state_d;
  logic [RST_W-1:0]      rst_cnt_q, rst_cnt_d;
  logic [RUN_W-1:0]      run_cnt_q, run_cnt_d;
  logic                  ready_q, ready_d;
  logic                  arst_q, arst_d;
  logic [CFG_ADDR_W-1:0] addr_q, addr_d;
  logic [CFG_DATA_W-1:0] data_q, data_d;
  logic                  cfg_done_q, cfg_done_d;
  logic                  run_done_q, run_done_d;
  logic [15:0]           beat_cnt_q, beat_cnt_d;
  logic                  beat_accept;

  // ready_q is 1 exactly while the FSM is in LOAD.
  // The handshake therefore never looks combinationally at cfg_valid_in.
  assign beat_accept = cfg_valid_in && ready_q;

  always_comb begin
    state_d    = state_q;
    rst_cnt_d  = rst_cnt_q;
    run_cnt_d  = run_cnt_q;
    addr_d     = '0;
    data_d     = '0;
    cfg_done_d = cfg_done_q;
    run_done_d = run_done_q;
    beat_cnt_d = beat_cnt_q;

    if (abort_in) begin
      // Abort wins over everything, including a beat accepted in the same cycle.
      state_d    = S_IDLE;
      rst_cnt_d  = '0;
      run_cnt_d  = '0;
      cfg_done_d = 1'b0;
      run_done_d = 1'b0;
      beat_cnt_d = '0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start_in) begin
            state_d    = S_ARST;
            rst_cnt_d  = '0;
            cfg_done_d = 1'b0;
            run_done_d = 1'b0;
            beat_cnt_d = '0;
          end
        end
        S_ARST: begin
          if (rst_cnt_q == RST_LAST) begin
            state_d   = S_LOAD;
            rst_cnt_d = '0;
          end else begin
            rst_cnt_d = rst_cnt_q + 1'b1;
          end
        end
        S_LOAD: begin
          if (beat_accept) begin
            // Address 0 is a legal beat.
            // It is forwarded and counted like any other beat.
            addr_d     = cfg_addr_in;
            data_d     = cfg_data_in;
            beat_cnt_d = (beat_cnt_q == 16'hFFFF) ? beat_cnt_q
                                                  : beat_cnt_q + 16'd1;
            if (cfg_last_in) begin
              state_d    = S_RUN;
              cfg_done_d = 1'b1;
              run_cnt_d  = '0;
            end
          end
        end
        S_RUN: begin
          if (run_cnt_q == RUN_LAST) begin
            state_d    = S_DONE;
            run_done_d = 1'b1;
            run_cnt_d  = '0;
          end else begin
            run_cnt_d = run_cnt_q + 1'b1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // The Moore outputs are registered from the next state.
  // This keeps them glitch-free and aligned with state_q.
  always_comb begin
    ready_d = (state_d == S_LOAD);
    arst_d  = (state_d == S_ARST);
  end

  always_ff @(posedge clk_in or negedge reset_in) begin
    if (!reset_in) begin
      state_q    <= S_IDLE;
      rst_cnt_q  <= '0;
      run_cnt_q  <= '0;
      ready_q    <= 1'b0;
      arst_q     <= 1'b0;
      addr_q     <= '0;
      data_q     <= '0;
      cfg_done_q <= 1'b0;
      run_done_q <= 1'b0;
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      rst_cnt_q  <= rst_cnt_d;
      run_cnt_q  <= run_cnt_d;
      ready_q    <= ready_d;
      arst_q     <= arst_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      cfg_done_q <= cfg_done_d;
      run_done_q <= run_done_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

  assign cfg_ready_out   = ready_q;
  assign array_reset_out = arst_q;
  assign config_addr_out = addr_q;
  assign config_data_out = data_q;
  assign config_done_out = cfg_done_q;
  assign run_done_out    = run_done_q;
  assign beat_count_out  = beat_cnt_q;

endmodule

// File: tb/tb_cgra_config_sequencer.sv
// ---------------------------------------------------------------------------
// tb_cgra_config_sequencer
//
// Directed bench for cgra_config_sequencer.
// It uses a session-level model of the sequencer.
// A per-cycle compare process checks the DUT against that model.
// Literal expectations after each scenario pin the model itself.
// ---------------------------------------------------------------------------
module tb_cgra_config_sequencer;

   localparam int RST_CYC = 3;
   localparam int RUN_CYC = 20;

   logic        clk_in = 1'b0;
   logic        reset_in;
   logic        start_in;
   logic        abort_in;
   logic        cfg_valid_in;
   logic        cfg_ready_out;
   logic [31:0] cfg_addr_in;
   logic [31:0] cfg_data_in;
   logic        cfg_last_in;
   logic        array_reset_out;
   logic [31:0] config_addr_out;
   logic [31:0] config_data_out;
   logic        config_done_out;
   logic        run_done_out;
   logic [15:0] beat_count_out;

   int checks = 0;
   int errors = 0;
   int arstCycles = 0;
   int busPulses = 0;

   cgra_config_sequencer #(
      .CFG_ADDR_W(32),
      .CFG_DATA_W(32),
      .RST_CYCLES(RST_CYC),
      .RUN_CYCLES(RUN_CYC)
   ) dut (
      .clk_in(clk_in),
      .reset_in(reset_in),
      .start_in(start_in),
      .abort_in(abort_in),
      .cfg_valid_in(cfg_valid_in),
      .cfg_ready_out(cfg_ready_out),
      .cfg_addr_in(cfg_addr_in),
      .cfg_data_in(cfg_data_in),
      .cfg_last_in(cfg_last_in),
      .array_reset_out(array_reset_out),
      .config_addr_out(config_addr_out),
      .config_data_out(config_data_out),
      .config_done_out(config_done_out),
      .run_done_out(run_done_out),
      .beat_count_out(beat_count_out)
   );

   // Free-running clock: rising edges at 5, 15, 25, ...
   always #5 clk_in = ~clk_in;

   // Session model.
   // It tracks which phase of the session we are in and how long we have
   // been there, plus the beats accepted so far.
   typedef enum {M_IDLE, M_ARST, M_LOAD, M_RUN, M_DONE} phase_e;
   phase_e      mPhase;
   int          mCycles;
   int          mBeats;
   bit          mCfgDone;
   bit          mRunDone;
   logic [31:0] mAddr;
   logic [31:0] mData;

   function automatic void modelClear();
      mPhase   = M_IDLE;
      mCycles  = 0;
      mBeats   = 0;
      mCfgDone = 1'b0;
      mRunDone = 1'b0;
      mAddr    = '0;
      mData    = '0;
   endfunction

   // Advance the model once per rising edge, reading the stimulus.
   // The model also reacts to reset at once, without waiting for an edge.
   always @(posedge clk_in or negedge reset_in) begin
      if (!reset_in) begin
         modelClear();
      end else begin
         mAddr = '0;
         mData = '0;
         if (abort_in) begin
            modelClear();
         end else begin
            case (mPhase)
               M_IDLE, M_DONE: if (start_in) begin
                  mPhase   = M_ARST;
                  mCycles  = 0;
                  mBeats   = 0;
                  mCfgDone = 1'b0;
                  mRunDone = 1'b0;
               end
               M_ARST: begin
                  mCycles++;
                  if (mCycles == RST_CYC) begin
                     mPhase  = M_LOAD;
                     mCycles = 0;
                  end
               end
               M_LOAD: if (cfg_valid_in) begin
                  mBeats++;
                  mAddr = cfg_addr_in;
                  mData = cfg_data_in;
                  if (cfg_last_in) begin
                     mCfgDone = 1'b1;
                     mPhase   = M_RUN;
                     mCycles  = 0;
                  end
               end
               M_RUN: begin
                  mCycles++;
                  if (mCycles == RUN_CYC) begin
                     mPhase   = M_DONE;
                     mRunDone = 1'b1;
                  end
               end
               default: ;
            endcase
         end
      end
   end

   function automatic void checkOutput(string name, logic [31:0] actual, logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, actual, expected);
      end
   endfunction

   function automatic void timeoutFail(string name);
      checks++;
      errors++;
      $display("[TB] FAIL %s at %0t: timed out waiting, expected event never seen", name, $time);
   endfunction

   // Compare every output against the model on each falling edge.
   // Also count reset-high cycles and nonzero bus cycles for the scenario checks.
   always @(negedge clk_in) begin
      checkOutput("array_reset", 32'(array_reset_out), 32'(mPhase == M_ARST));
      checkOutput("cfg_ready", 32'(cfg_ready_out), 32'(mPhase == M_LOAD));
      checkOutput("config_addr", config_addr_out, mAddr);
      checkOutput("config_data", config_data_out, mData);
      checkOutput("config_done", 32'(config_done_out), 32'(mCfgDone));
      checkOutput("run_done", 32'(run_done_out), 32'(mRunDone));
      checkOutput("beat_count", 32'(beat_count_out),
                  (mBeats > 65535) ? 32'hFFFF : 32'(mBeats));
      if (array_reset_out) arstCycles++;
      if (config_addr_out != 0 || config_data_out != 0) busPulses++;
   end

   // Drive one cycle of inputs at a falling edge.
   // Return at the next falling edge.
   task automatic applyStimulus(input bit start, input bit abort, input bit valid,
                                input logic [31:0] addr, input logic [31:0] data,
                                input bit last);
      start_in     = start;
      abort_in     = abort;
      cfg_valid_in = valid;
      cfg_addr_in  = addr;
      cfg_data_in  = data;
      cfg_last_in  = last;
      @(negedge clk_in);
   endtask

   task automatic idleCycles(input int n);
      for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0, 0, 0);
   endtask

   task automatic waitReady();
      start_in     = 1'b0;
      abort_in     = 1'b0;
      cfg_valid_in = 1'b0;
      cfg_last_in  = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (cfg_ready_out) return;
         @(negedge clk_in);
      end
      timeoutFail("wait_cfg_ready");
   endtask

   task automatic waitRunDone();
      cfg_valid_in = 1'b0;
      for (int i = 0; i < RUN_CYC + 10; i++) begin
         if (run_done_out) return;
         @(negedge clk_in);
      end
      timeoutFail("wait_run_done");
   endtask

   // Send one beat, then check that it appears on the config buses
   // in the cycle right after it is accepted.
   task automatic sendBeat(input logic [31:0] addr, input logic [31:0] data, input bit last);
      applyStimulus(0, 0, 1, addr, data, last);
      checkOutput("beat_addr_fwd", config_addr_out, addr);
      checkOutput("beat_data_fwd", config_data_out, data);
   endtask

   initial begin
      reset_in     = 1'b0;
      start_in     = 1'b0;
      abort_in     = 1'b0;
      cfg_valid_in = 1'b0;
      cfg_addr_in  = '0;
      cfg_data_in  = '0;
      cfg_last_in  = 1'b0;

      // Reset state.
      repeat (2) @(negedge clk_in);
      checkOutput("reset_array_reset", 32'(array_reset_out), 32'd0);
      checkOutput("reset_cfg_ready", 32'(cfg_ready_out), 32'd0);
      checkOutput("reset_beat_count", 32'(beat_count_out), 32'd0);
      reset_in = 1'b1;
      idleCycles(3);
      checkOutput("idle_after_reset", 32'(array_reset_out), 32'd0);

      // Nominal session.
      $display("[TB] nominal session");
      arstCycles = 0;
      busPulses  = 0;
      applyStimulus(1, 0, 0, 0, 0, 0);
      waitReady();
      sendBeat(32'h10, 32'hA, 0);
      sendBeat(32'h20, 32'hB, 0);
      sendBeat(32'h30, 32'hC, 1);
      checkOutput("nom_ready_drop", 32'(cfg_ready_out), 32'd0);
      waitRunDone();
      checkOutput("nom_arst_cycles", 32'(arstCycles), 32'd3);
      checkOutput("nom_bus_pulses", 32'(busPulses), 32'd3);
      checkOutput("nom_beat_count", 32'(beat_count_out), 32'd3);
      checkOutput("nom_config_done", 32'(config_done_out), 32'd1);
      checkOutput("nom_run_done", 32'(run_done_out), 32'd1);

      // Bubbles in the beat stream, restarted from DONE.
      $display("[TB] bubbles");
      busPulses = 0;
      applyStimulus(1, 0, 0, 0, 0, 0);
      waitReady();
      applyStimulus(0, 0, 1, 32'h40, 32'hD, 0);
      applyStimulus(0, 0, 0, 32'h41, 32'h1, 0);
      applyStimulus(0, 0, 0, 32'h42, 32'h2, 0);
      applyStimulus(0, 0, 1, 32'h50, 32'hE, 1);
      idleCycles(2);
      checkOutput("bub_bus_pulses", 32'(busPulses), 32'd2);
      checkOutput("bub_beat_count", 32'(beat_count_out), 32'd2);
      checkOutput("bub_run_done", 32'(run_done_out), 32'd0);

      // Abort mid-LOAD after 1 of 3 beats.
      $display("[TB] abort mid-load");
      applyStimulus(0, 1, 0, 0, 0, 0);
      applyStimulus(1, 0, 0, 0, 0, 0);
      waitReady();
      sendBeat(32'h60, 32'h6, 0);
      applyStimulus(0, 1, 1, 32'h61, 32'h7, 0);
      checkOutput("abort_ready", 32'(cfg_ready_out), 32'd0);
      checkOutput("abort_addr", config_addr_out, 32'd0);
      checkOutput("abort_data", config_data_out, 32'd0);
      checkOutput("abort_beat_count", 32'(beat_count_out), 32'd0);
      checkOutput("abort_config_done", 32'(config_done_out), 32'd0);
      arstCycles = 0;
      applyStimulus(1, 0, 0, 0, 0, 0);
      waitReady();
      checkOutput("restart_arst_cycles", 32'(arstCycles), 32'd3);
      checkOutput("restart_beat_count", 32'(beat_count_out), 32'd0);
      sendBeat(32'h0, 32'h77, 0);
      sendBeat(32'h70, 32'h0, 0);
      sendBeat(32'h80, 32'h99, 1);
      checkOutput("zero_addr_beat_count", 32'(beat_count_out), 32'd3);

      // Asynchronous reset mid-RUN, between clock edges.
      $display("[TB] async reset mid-run");
      idleCycles(5);
      checkOutput("pre_reset_config_done", 32'(config_done_out), 32'd1);
      #3;
      reset_in = 1'b0;
      #1;
      checkOutput("async_config_done", 32'(config_done_out), 32'd0);
      checkOutput("async_beat_count", 32'(beat_count_out), 32'd0);
      checkOutput("async_run_done", 32'(run_done_out), 32'd0);
      checkOutput("async_ready", 32'(cfg_ready_out), 32'd0);
      @(negedge clk_in);
      idleCycles(2);
      reset_in = 1'b1;
      idleCycles(RUN_CYC + 5);
      checkOutput("post_reset_run_done", 32'(run_done_out), 32'd0);
      checkOutput("post_reset_idle", 32'(array_reset_out), 32'd0);

      // Start and abort together in DONE.
      $display("[TB] start+abort in done");
      applyStimulus(1, 0, 0, 0, 0, 0);
      waitReady();
      sendBeat(32'h90, 32'h5, 1);
      waitRunDone();
      checkOutput("sa_run_done_before", 32'(run_done_out), 32'd1);
      arstCycles = 0;
      applyStimulus(1, 1, 0, 0, 0, 0);
      idleCycles(3);
      checkOutput("sa_arst_cycles", 32'(arstCycles), 32'd0);
      checkOutput("sa_run_done", 32'(run_done_out), 32'd0);
      checkOutput("sa_config_done", 32'(config_done_out), 32'd0);

      // Beat counter saturation.
      $display("[TB] saturation");
      applyStimulus(1, 0, 0, 0, 0, 0);
      waitReady();
      for (int i = 0; i < 32'h10005; i++)
         applyStimulus(0, 0, 1, 32'(i + 1), ~32'(i), i == 32'h10004);
      idleCycles(1);
      checkOutput("sat_beat_count", 32'(beat_count_out), 32'hFFFF);
      checkOutput("sat_config_done", 32'(config_done_out), 32'd1);
      waitRunDone();
      checkOutput("sat_run_done", 32'(run_done_out), 32'd1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
